// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;
  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory request/response channel between fetch (master) and imem (slave).
interface fetch_prefetch_queue_if #(parameter int WIDTH = 32);
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [WIDTH-1:0] imem_req_addr;
  logic             imem_rsp_valid;
  logic [WIDTH-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; D must be a power of two.
module sync_fifo #(
  parameter int W = 32,
  parameter int D = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(D+1)-1:0] count
);
  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D + 1);

  logic [D-1:0][W-1:0] ram;
  logic [AW-1:0]       wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: reads are qualified by empty.
  always_ff @(posedge clk) begin
    if (push && !clear) ram[wr_ptr] <= din;
  end

  assign dout  = ram[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(D));
endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: variable-latency imem front end feeding decode through an in-order prefetch queue.
// Redirects flush the queue and turn every outstanding request stale.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   PCSrcE,
  input  logic [WIDTH-1:0]       PCTargetE,
  input  logic                   StallD,
  fetch_prefetch_queue_if.master mem,
  output logic                   ValidF,
  output logic [WIDTH-1:0]       InstrF,
  output logic [WIDTH-1:0]       PCF,
  output logic [WIDTH-1:0]       PCPlus4F
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = $bits(fetch_entry_t);

  logic [WIDTH-1:0] pc_issue, rsp_pc, target;
  logic [CW-1:0]    occ, inflight, drop;
  logic             q_full, q_empty, pc_full, pc_empty;
  logic             accept, rsp_fire, push, pop;
  fetch_entry_t     rsp_entry, head;

  assign target = PCTargetE & ~WIDTH'(3);

  assign mem.imem_req_valid = rst && !PCSrcE &&
                              ((CW+1)'(occ) + (CW+1)'(inflight) < (CW+1)'(DEPTH));
  assign mem.imem_req_addr  = pc_issue;
  assign accept             = mem.imem_req_valid && mem.imem_req_ready;

  // The PC FIFO occupancy is the in-flight count; every response retires one, live or stale.
  assign rsp_fire  = mem.imem_rsp_valid && !pc_empty;
  assign push      = rsp_fire && !PCSrcE && (drop == '0);
  assign pop       = !q_empty && !StallD && !PCSrcE;
  assign rsp_entry = '{pc: rsp_pc, instr: mem.imem_rsp_data};

  sync_fifo #(.W(WIDTH), .D(DEPTH)) u_pc_fifo (
    .clk(clk), .rst(rst), .push(accept), .pop(rsp_fire), .clear(1'b0),
    .din(pc_issue), .dout(rsp_pc), .full(pc_full), .empty(pc_empty), .count(inflight)
  );

  sync_fifo #(.W(EW), .D(DEPTH)) u_queue (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(PCSrcE),
    .din(rsp_entry), .dout(head), .full(q_full), .empty(q_empty), .count(occ)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_issue <= RESET_PC;
      drop     <= '0;
    end else if (PCSrcE) begin
      pc_issue <= target;
      drop     <= inflight - CW'(rsp_fire);
    end else begin
      if (accept) pc_issue <= pc_issue + WIDTH'(4);
      if (rsp_fire && drop != '0) drop <= drop - CW'(1);
    end
  end

  assign ValidF   = !q_empty;
  assign InstrF   = q_empty ? WIDTH'(NOP_INSTR) : head.instr;
  assign PCF      = q_empty ? '0 : head.pc;
  assign PCPlus4F = q_empty ? '0 : head.pc + WIDTH'(4);

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
    mem.imem_rsp_valid |-> !pc_empty);
  a_queue_room:   assert property (@(posedge clk) disable iff (!rst) !(push && q_full));
  a_pc_room:      assert property (@(posedge clk) disable iff (!rst) !(accept && pc_full));
endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Replacement instruction-fetch stage with a variable-latency instruction memory interface and a small in-order prefetch queue. It sits directly upstream of the decode stage and supplies InstrF, PCF and PCPlus4F. It adds a ValidF qualifier and accepts a StallD back-pressure input. Branch and jump redirects from execute (PCSrcE, PCTargetE) flush the queue and discard stale in-flight memory responses.

Parameters:
WIDTH, 32, data/address width
DEPTH, 4, prefetch queue entries; also the cap on queued plus in-flight requests (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
PCSrcE  in  1  redirect request from execute
PCTargetE  in  WIDTH  redirect target; bits [1:0] are ignored and treated as 0
StallD  in  1  decode cannot accept this cycle
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  WIDTH  word-aligned fetch address
imem_rsp_valid  in  1  response valid; in order, at least 1 cycle after acceptance
imem_rsp_data  in  WIDTH  instruction word
ValidF  out  1  head entry valid
InstrF  out  WIDTH  head instruction
PCF  out  WIDTH  head PC
PCPlus4F  out  WIDTH  PCF+4

Behaviour:
- State:
  - pc_issue: next address to request
  - queue of {pc, instr}, DEPTH entries, occupancy occ
  - inflight: accepted requests not yet answered, 0..DEPTH
  - drop: stale inflight requests, drop <= inflight
- Reset (rst=0, async):
  - pc_issue=RESET_PC; occ=inflight=drop=0
  - ValidF=0, imem_req_valid=0
  - Outputs while queue is empty: InstrF=32'h0000_0013 (NOP), PCF=0, PCPlus4F=0
- Issue:
  - imem_req_valid = !PCSrcE && (occ + inflight < DEPTH); imem_req_addr = pc_issue
  - A request is accepted on valid&&ready: inflight+1, pc_issue += 4 (modulo 2^WIDTH; 0xFFFF_FFFC wraps to 0)
  - imem_req_addr is held stable while valid && !ready
- Response:
  - If drop>0: data discarded; drop-1, inflight-1
  - Else: push {pc of oldest live request, data} into the queue; inflight-1
  - The PC is tracked by a companion FIFO of issued addresses, or computed as head/tail PC +4
  - No combinational bypass: response at edge t gives ValidF=1 at cycle t+1 at the earliest
- Output and pop:
  - ValidF = (occ != 0); InstrF, PCF, PCPlus4F are registered head fields
  - Pop when ValidF && !StallD && !PCSrcE
- Redirect (PCSrcE=1), highest priority:
  - Queue cleared (occ=0 next cycle); no pop and no issue that cycle
  - pc_issue <= {PCTargetE[WIDTH-1:2],2'b00}
  - A response arriving the same cycle is discarded
  - drop <= inflight - (imem_rsp_valid ? 1 : 0); i.e. every remaining outstanding request becomes stale
  - Back-to-back redirects: the last one wins; drop is recomputed each cycle
- Redirect timing: PCSrcE at cycle t gives imem_req_addr=target at t+1, and the target instruction on ValidF at t+3 at the earliest with 1-cycle memory
- Simultaneous push and pop: occ unchanged. Push is never refused, because the issue cap guarantees space.
- imem_rsp_valid while inflight==0 is a protocol error: ignored, and a simulation assertion fires
- Reset asserted mid-operation: all state cleared immediately; responses for pre-reset requests are the memory's responsibility to squash

Decomposition:
- fetch_pkg holds:
  - NOP_INSTR constant
  - fetch_entry_t struct {pc, instr}
  - Default RESET_PC localparam
- One sub-module: sync_fifo (parameterised width/depth, push/pop/clear, full/empty/count), instantiated for the queue and for the issued-PC tracking FIFO

Test Plan:
1. Reset, 1-cycle memory always ready, StallD=0 -> requests at 0,4,8,...; ValidF rises cycle 3 with PCF=0, PCPlus4F=4, then one instruction per cycle.
2. StallD=1 for 10 cycles -> exactly DEPTH=4 requests issued, then imem_req_valid=0; head stays PCF=0; on release, PCF steps 0,4,8,12,16 with no gap.
3. Memory latency 3, PCSrcE pulse with PCTargetE=0x0000_0103 while 3 requests are in flight -> 3 responses discarded, queue empty, next request address 0x100, first ValidF shows PCF=0x100.
4. Redirect in the same cycle as a response and a non-stalled pop -> response dropped, no pop, drop=inflight-1, occ=0 next cycle.
5. imem_req_ready held low 5 cycles -> imem_req_addr constant and inflight unchanged; fetch resumes cleanly.
6. RESET_PC=0xFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; assert rst mid-stream -> ValidF=0 and InstrF=0x13 immediately.
